ha_serial_add_ctrl: RTL and testbench
=====================================

Name: ha_serial_add_ctrl

Overview:
- Sequencer that performs a WIDTH-bit unsigned addition by time-sharing one external 1-bit half adder (`adder`: A, B in; S, C out).
- Each bit takes two half-adder passes:
  - pass 1: operand bits;
  - pass 2: partial sum plus running carry.
- Result is returned on a valid/ready output with carry-out.
- Sits between an operand source and a single `adder` instance wired to its HA_* ports.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 1

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
IN_VALID  input  1  operand pair valid
IN_READY  output  1  block can accept operands
OP_A  input  WIDTH  operand A
OP_B  input  WIDTH  operand B
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
SUM  output  WIDTH  OP_A+OP_B modulo 2^WIDTH
COUT  output  1  carry out of bit WIDTH-1
HA_A  output  1  drives adder A
HA_B  output  1  drives adder B
HA_S  input  1  adder S (combinational from HA_A/HA_B, same cycle)
HA_C  input  1  adder C

Behaviour:
- Clocking and reset:
  - One clock CLK.
  - RST is asynchronous, active-high.
  - All state registers reset immediately on RST=1.
- Reset values:
  - state=IDLE; bit index=0; carry=0; s1=0; c1=0.
  - Latched operands=0; SUM=0; COUT=0; OUT_VALID=0.
  - HA_A=0, HA_B=0.
  - IN_READY=1, since it is decoded from IDLE.
- States: IDLE, PH0, PH1, DONE (registered FSM). Let idx be the bit index.
- IDLE:
  - IN_READY=1; HA_A=HA_B=0.
  - On IN_VALID&IN_READY at an edge: latch OP_A/OP_B; carry<=0; idx<=0; SUM<=0; COUT<=0; go to PH0.
- PH0:
  - HA_A=opa[idx], HA_B=opb[idx].
  - At the edge: s1<=HA_S, c1<=HA_C; go to PH1.
- PH1:
  - HA_A=s1, HA_B=carry.
  - At the edge: SUM[idx]<=HA_S; carry<=c1|HA_C.
  - If idx==WIDTH-1: COUT<=c1|HA_C and go to DONE.
  - Else: idx<=idx+1 and go to PH0.
- DONE:
  - OUT_VALID=1; SUM/COUT held stable; IN_READY=0.
  - On OUT_READY=1 at an edge: go to IDLE.
- Handshakes:
  - IN_READY=0 in PH0/PH1/DONE. IN_VALID is ignored there; no operand is captured.
  - OUT_VALID deasserts the cycle after the accepting edge.
  - There is no back-to-back overlap: a new input can be accepted at the earliest one cycle after output handshake, i.e. in IDLE.
- Latency:
  - Input handshake edge to OUT_VALID=1 is exactly 2*WIDTH clock edges (16 for WIDTH=8).
  - Output handshake to IN_READY=1: next cycle.
- HA_A/HA_B:
  - Combinational from state, idx and registers only; no combinational path from HA_S/HA_C.
  - Forced to 0 in IDLE and DONE.
- Invariant: c1 and the pass-2 HA_C are never both 1. Assert this; OR == XOR for carry.
- idx width: max(1, clog2(WIDTH)). WIDTH=1 completes in 2 cycles.
- Reset mid-operation (any state): aborts immediately; no OUT_VALID is produced; the block returns to IDLE with the reset values above.
- SUM during PH0/PH1 is partial and undefined for the consumer. Only SUM/COUT sampled with OUT_VALID=1 are architectural.

Test Plan:
- WIDTH=8, RST pulse then release:
  - all outputs at reset values, IN_READY=1.
  - Apply 0x00+0x00 -> OUT_VALID exactly 16 cycles after accept; SUM=0x00, COUT=0.
- 0xFF+0x01 -> SUM=0x00, COUT=1.
- 0xA5+0x5A -> SUM=0xFF, COUT=0.
- 0x80+0x80 -> SUM=0x00, COUT=1.
- 0x3C+0x0F -> SUM=0x4B, COUT=0; check HA_A/HA_B equal operand bits in every PH0 cycle.
- Backpressure:
  - hold OUT_READY=0 for 5 cycles in DONE -> SUM/COUT stable, IN_READY=0.
  - Drive IN_VALID=1 with new operands meanwhile -> not captured.
  - Release OUT_READY -> OUT_VALID=0 next cycle, IN_READY=1.
- Reset abort: assert RST asynchronously (mid-cycle) 7 cycles into 0xFF+0xFF -> outputs go to reset values immediately; no OUT_VALID ever appears for that operation; next 0x01+0x02 -> SUM=0x03, COUT=0.

Source files
------------

// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer that time-shares one external
// half adder, using two passes per bit (operand bits, then sum + carry).
module ha_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             HA_A,
    output logic             HA_B,
    input  logic             HA_S,
    input  logic             HA_C
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_s1;
    logic             r_c1;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_last;
    logic             w_carry_nxt;

    assign w_last      = (r_idx == IW'(WIDTH - 1));
    // c1 and the second-pass carry are exclusive, so OR equals XOR here
    assign w_carry_nxt = r_c1 | HA_C;
    assign SUM         = r_sum;
    assign COUT        = r_cout;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (IN_VALID) w_next = PH0;
            PH0:  w_next = PH1;
            PH1:  w_next = w_last ? DONE : PH0;
            DONE: if (OUT_READY) w_next = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        HA_A      = 1'b0;
        HA_B      = 1'b0;
        unique case (r_state)
            IDLE: IN_READY = 1'b1;
            PH0: begin
                HA_A = r_opa[r_idx];
                HA_B = r_opb[r_idx];
            end
            PH1: begin
                HA_A = r_s1;
                HA_B = r_carry;
            end
            DONE: OUT_VALID = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_s1    <= 1'b0;
            r_c1    <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_opa   <= OP_A;
                        r_opb   <= OP_B;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                PH0: begin
                    r_s1 <= HA_S;
                    r_c1 <= HA_C;
                end
                PH1: begin
                    r_sum[r_idx] <= HA_S;
                    r_carry      <= w_carry_nxt;
                    if (w_last) begin
                        r_cout <= w_carry_nxt;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    a_carry_excl: assert property (
        @(posedge CLK) disable iff (RST)
        (r_state == PH1) |-> !(r_c1 && HA_C)
    );

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Randomised and directed bench for ha_serial_add_ctrl with a
// transaction-level model and a bench-side half adder.
module tb_ha_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ha_a;
    logic         ha_b;
    logic         ha_s;
    logic         ha_c;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b0;

    always #5 clk = ~clk;

    assign ha_s = ha_a ^ ha_b;
    assign ha_c = ha_a & ha_b;

    ha_serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .OP_A(op_a), .OP_B(op_b),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .SUM(sum), .COUT(cout),
        .HA_A(ha_a), .HA_B(ha_b),
        .HA_S(ha_s), .HA_C(ha_c)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction model: 0 idle, 1 busy (edge count m_cnt), 2 done
    int          m_mode = 0;
    int          m_cnt  = 0;
    int unsigned m_a    = 0;
    int unsigned m_b    = 0;
    int unsigned m_res  = 0;
    int unsigned m_shown = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  = 0;
            m_cnt   = 0;
            m_shown = 0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    m_a    = op_a;
                    m_b    = op_b;
                    m_res  = m_a + m_b;
                    m_cnt  = 0;
                    m_mode = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 2 * W) begin
                        m_mode  = 2;
                        m_shown = m_res;
                    end
                end
                default: if (out_ready) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (run_chk && !rst) begin
            int k;
            int unsigned mask;
            chk("in_ready", in_ready, m_mode == 0);
            chk("out_valid", out_valid, m_mode == 2);
            if (m_mode == 1) begin
                k    = m_cnt / 2;
                mask = (32'd1 << k) - 1;
                if (m_cnt % 2 == 0) begin
                    chk("ha_a_ph0", ha_a, (m_a >> k) & 1);
                    chk("ha_b_ph0", ha_b, (m_b >> k) & 1);
                end else begin
                    chk("ha_a_ph1", ha_a, ((m_a ^ m_b) >> k) & 1);
                    chk("ha_b_ph1", ha_b,
                        (((m_a & mask) + (m_b & mask)) >> k) & 1);
                end
            end else begin
                chk("ha_a_zero", ha_a, 0);
                chk("ha_b_zero", ha_b, 0);
                chk("sum_model", sum, m_shown & 8'hFF);
                chk("cout_model", cout, (m_shown >> W) & 1);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec,
                         input int hold);
        int n;
        logic [W-1:0] s0;
        logic c0;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", n, 2 * W);
        chk("sum_lit", sum, es);
        chk("cout_lit", cout, ec);
        s0 = sum;
        c0 = cout;
        repeat (hold) begin
            in_valid = 1'b1;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_sum", sum, s0);
            chk("hold_cout", cout, c0);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W:0]   rs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ha", {ha_a, ha_b}, 0);
        run_chk = 1'b1;

        do_op(8'h00, 8'h00, 8'h00, 1'b0, 0);
        do_op(8'hFF, 8'h01, 8'h00, 1'b1, 0);
        do_op(8'hA5, 8'h5A, 8'hFF, 1'b0, 0);
        do_op(8'h80, 8'h80, 8'h00, 1'b1, 0);
        do_op(8'h3C, 8'h0F, 8'h4B, 1'b0, 0);
        do_op(8'h12, 8'h34, 8'h46, 1'b0, 5);

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = ra + rb;
            do_op(ra, rb, rs[W-1:0], rs[W], $urandom_range(0, 3));
        end

        op_a     = 8'hFF;
        op_b     = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ha", {ha_a, ha_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        do_op(8'h01, 8'h02, 8'h03, 1'b0, 0);

        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
